// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } md_state_e;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM
  function automatic logic op_a_signed(input logic [2:0] op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Bit-serial RV32M multiply/divide unit: one op at a time, shared shift register
// and adder, sign fix-up cycle, write-back packet on a one-cycle done.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic [2:0]            op_i,
  input  logic [XLEN-1:0]       r1_i,
  input  logic [XLEN-1:0]       r2_i,
  input  logic [REG_ADDR_W-1:0] w_addr_i,
  input  logic                  w_req_i,
  output logic                  busy_o,
  output logic                  stall_req_o,
  output logic                  done_o,
  output logic [REG_ADDR_W-1:0] w_addr_o,
  output logic                  w_req_o,
  output logic [XLEN-1:0]       w_data_o
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned ACC_W = 2 * XLEN;
  localparam int unsigned SUM_W = XLEN + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  md_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [XLEN-1:0]       b_q, b_d;
  logic [2:0]            op_q, op_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [REG_ADDR_W-1:0] res_addr_q, res_addr_d;
  logic                  wreq_q, wreq_d;
  logic                  negp_q, negp_d;
  logic                  negr_q, negr_d;
  logic [XLEN-1:0]       res_q, res_d;

  // Operand conditioning at issue time
  logic            sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, spec_word;

  assign sa        = op_a_signed(op_i) & r1_i[XLEN-1];
  assign sb        = op_b_signed(op_i) & r2_i[XLEN-1];
  assign mag_a     = sa ? -r1_i : r1_i;
  assign mag_b     = sb ? -r2_i : r2_i;
  assign div_zero  = op_i[2] & (r2_i == '0);
  assign div_ovf   = op_i[2] & ~op_i[0] & (r1_i == MIN_NEG) & (r2_i == ALL_ONE);
  assign spec_word = div_zero ? (op_i[1] ? r1_i : ALL_ONE)
                              : (op_i[1] ? '0   : r1_i);

  // Shared adder: adds the multiplicand for multiply, subtracts the divisor for divide
  logic             is_div_q;
  logic [XLEN:0]    add_a, add_b, sum;

  assign is_div_q = op_q[2];
  assign add_a    = is_div_q ? acc_q[ACC_W-1:XLEN-1] : {1'b0, acc_q[ACC_W-1:XLEN]};
  assign add_b    = is_div_q ? ~{1'b0, b_q} : {1'b0, b_q};
  assign sum      = add_a + add_b + SUM_W'(is_div_q);

  // Sign correction and word selection
  logic [ACC_W-1:0] prod_fix;
  logic [XLEN-1:0]  quo_fix, rem_fix, fix_word;

  assign prod_fix = negp_q ? -acc_q : acc_q;
  assign quo_fix  = negp_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = negr_q ? -acc_q[ACC_W-1:XLEN] : acc_q[ACC_W-1:XLEN];
  assign fix_word = is_div_q ? (op_q[1] ? rem_fix : quo_fix)
                             : ((op_q == MD_MUL) ? prod_fix[XLEN-1:0] : prod_fix[ACC_W-1:XLEN]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    b_d        = b_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wreq_d     = wreq_q;
    negp_d     = negp_q;
    negr_d     = negr_q;
    res_d      = '0;
    res_addr_d = '0;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (start_i) begin
            op_d   = op_i;
            addr_d = w_addr_i;
            wreq_d = w_req_i;
            cnt_d  = '0;
            negp_d = sa ^ sb;
            negr_d = sa;
            // divide: dividend in low half; multiply: multiplier in low half
            b_d    = op_i[2] ? mag_b : mag_a;
            acc_d  = {{XLEN{1'b0}}, (op_i[2] ? mag_a : mag_b)};
            if (div_zero | div_ovf) begin
              state_d    = ST_DONE;
              res_d      = spec_word;
              res_addr_d = w_addr_i;
            end else begin
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_div_q) begin
            acc_d = sum[XLEN] ? {acc_q[ACC_W-2:0], 1'b0}
                              : {sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[ACC_W-1:1]};
          end
          if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_FIX;
        end
        ST_FIX: begin
          state_d    = ST_DONE;
          res_d      = fix_word;
          res_addr_d = addr_q;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      wreq_q     <= 1'b0;
      negp_q     <= 1'b0;
      negr_q     <= 1'b0;
      res_q      <= '0;
      res_addr_q <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wreq_q     <= wreq_d;
      negp_q     <= negp_d;
      negr_q     <= negr_d;
      res_q      <= res_d;
      res_addr_q <= res_addr_d;
    end
  end

  assign busy_o      = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign stall_req_o = (start_i & ~flush_i) | busy_o;
  assign done_o      = (state_q == ST_DONE);
  assign w_req_o     = done_o & wreq_q & ~flush_i;
  assign w_data_o    = res_q;
  assign w_addr_o    = res_addr_q;

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide execute unit, parametrised in data width, sitting beside the single-cycle integer ALU in the EX stage. Accepts one M-extension operation at a time, computes it bit-serially over multiple cycles while holding the pipeline through a stall request, and returns a register write-back packet in the same format the ALU produces. Supports branch-flush abort and the global `rdy` freeze.

## Interface
- `XLEN`, 32: operand and result width; must be ≥ 8 and a power of two.
- `REG_ADDR_W`, 5: destination register address width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  global ready; low freezes all state.
- `start_i`  in  1  issue request for a new operation.
- `flush_i`  in  1  pipeline flush (mispredict); aborts work.
- `op_i`  in  3  RV32M funct3 opcode.
- `r1_i`, `r2_i`  in  XLEN  rs1 and rs2 operand values.
- `w_addr_i`  in  REG_ADDR_W  destination register.
- `w_req_i`  in  1  write-back enable for the operation.
- `busy_o`  out  1  unit is occupied; start not accepted.
- `stall_req_o`  out  1  stall request to the pipeline controller.
- `done_o`  out  1  result valid; asserted for one cycle.
- `w_addr_o`  out  REG_ADDR_W  destination register for the result.
- `w_req_o`  out  1  write-back enable for the result.
- `w_data_o`  out  XLEN  result value.

## Operation
- Opcodes: 000 MUL (low word), 001 MULH (signed×signed, high word), 010 MULHSU (signed×unsigned, high word), 011 MULHU (unsigned×unsigned, high word), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, CALC, FIX, DONE.
- Acceptance happens at a rising edge when `rdy` is 1, `start_i` is 1, `flush_i` is 0, and the state is IDLE or DONE. On acceptance the unit latches `op`, `w_addr`, and `w_req`. It converts signed operands to magnitude, records the result sign, and clears the step counter.
- CALC runs one bit per cycle for XLEN cycles:
  - Multiply uses shift-add into a 2·XLEN accumulator.
  - Divide uses restoring division, producing an XLEN-bit quotient and remainder.
  - The step counter is log2(XLEN)+1 bits wide.
- FIX applies sign correction in one cycle:
  - Multiply: two's-complement negate of the 2·XLEN product.
  - Quotient sign is sign(a) XOR sign(b); remainder sign is sign(a).
- DONE lasts one cycle. `done_o` is 1, `w_data_o` holds the selected word, and `w_req_o` equals `latched_w_req & ~flush_i`. Outputs are cleared when leaving DONE.
- Special cases are detected at acceptance and go directly to DONE, skipping CALC and FIX:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return the dividend.
  - Signed overflow (dividend = min-negative, divisor = −1): DIV returns the dividend; REM returns 0.
- `flush_i` = 1 at an edge returns the unit to IDLE from any state with no `done_o`. Flush takes priority over a simultaneous `start_i`.
- `start_i` while in CALC or FIX is ignored; the pipeline must hold it because of the stall.
- `stall_req_o` = (`start_i` & ~`flush_i`) | (state ∈ {CALC, FIX}).
- `busy_o` = state ∈ {CALC, FIX}.

## Timing
- Reset values: state IDLE. `busy_o`, `stall_req_o` (with `start_i`=0), `done_o`, and `w_req_o` are 0; `w_addr_o` is 0; `w_data_o` is 0.
- Normal latency: accept at edge E0. `done_o` is high during the cycle after edge E0+XLEN+1, i.e. XLEN+2 edges after issue. For XLEN=32 this is 34 cycles.
- Special-case latency: `done_o` is high in the cycle immediately after the acceptance edge.
- `rdy` = 0 freezes state, counter, and datapath. Outputs hold their values, so latency stretches by exactly the number of low cycles.
- Back-to-back issue: a start accepted in the DONE cycle enters CALC on the next edge; the DONE output is still delivered.
- Reset asserted mid-operation immediately forces the reset values; no result is produced.

## Structure
- Shared package `muldiv_pkg` holds:
  - the 3-bit opcode constants `MD_MUL`…`MD_REMU`;
  - the FSM state enum;
  - the default XLEN constant.
- Single module with no sub-module. Multiply and divide share one 2·XLEN shift register and one XLEN-bit adder/subtractor.

## Test plan
- MUL 7 × 0xFFFFFFFD → `w_data_o` = 0xFFFFFFEB with `done_o` exactly 34 cycles after issue, and `stall_req_o` high throughout.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; MULHU on the same operands → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM on the same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14.
- DIVU 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5, both one cycle after issue. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0.
- Abort and stretch:
  - `flush_i` 10 cycles into a DIV → no `done_o`, `busy_o` low next cycle, and a new MUL is accepted.
  - `rdy` low for 5 cycles mid-MUL → `done_o` at cycle 39.
  - `rst_n` pulse mid-op → all outputs return to 0 immediately.
- XLEN=16 instance: MUL 0x0100 × 0x0100 → 0x0000 and MULHU → 0x0001, with `done_o` 18 cycles after issue.
